// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider: each channel produces a 50%-duty divided
// clock and a one-cycle tick, with divisor updates deferred to the next wrap.
module clock_divider_prog #(
    parameter int          CNT_W       = 27,
    parameter int          NUM_CH      = 2,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    localparam int         SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              in_clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              div_we,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_data,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        localparam logic [SEL_W-1:0] CH_IDX = SEL_W'(ch);

        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] active_div;
        logic [CNT_W-1:0] shadow_div;
        logic             out_r;
        logic             tick_r;
        logic             pend_r;
        logic             wr_hit;
        logic             wrap;

        // Out-of-range selects never match any channel index, so they are dropped here.
        assign wr_hit = div_we && (div_sel == CH_IDX);
        assign wrap   = (count == active_div);

        always_ff @(posedge in_clk or negedge rst_n) begin
            if (!rst_n) begin
                count      <= '0;
                active_div <= DIV_RST;
                shadow_div <= DIV_RST;
                out_r      <= 1'b0;
                tick_r     <= 1'b0;
                pend_r     <= 1'b0;
            end else if (!en[ch]) begin
                // Idle channel: a pending divisor can be adopted without any glitch risk.
                count  <= '0;
                out_r  <= 1'b0;
                tick_r <= 1'b0;
                if (wr_hit) begin
                    shadow_div <= div_data;
                    pend_r     <= 1'b1;
                end else if (pend_r) begin
                    active_div <= shadow_div;
                    pend_r     <= 1'b0;
                end
            end else if (wrap) begin
                count  <= '0;
                tick_r <= 1'b1;
                out_r  <= ~out_r;
                if (wr_hit) begin
                    active_div <= div_data;
                    shadow_div <= div_data;
                    pend_r     <= 1'b0;
                end else if (pend_r) begin
                    active_div <= shadow_div;
                    pend_r     <= 1'b0;
                end
            end else begin
                // count < active_div here, so the increment cannot overflow.
                count  <= count + CNT_W'(1);
                tick_r <= 1'b0;
                if (wr_hit) begin
                    shadow_div <= div_data;
                    pend_r     <= 1'b1;
                end
            end
        end

        assign out_clk[ch] = out_r;
        assign tick[ch]    = tick_r;
        assign pending[ch] = pend_r;
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: a per-cycle vector table for the running
// sequences plus hand-written reset and out-of-range-select sequences.
module tb_clock_divider_prog;

    typedef struct {
        logic [1:0] en;
        logic       we;
        logic       sel;
        logic [7:0] data;
        logic [1:0] tick;
        logic [1:0] oclk;
        logic [1:0] pend;
    } vec_t;

    logic       in_clk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] en     = 2'b00;
    logic       div_we = 1'b0;
    logic       div_sel = 1'b0;
    logic [7:0] div_data = 8'd0;
    logic [1:0] out_clk;
    logic [1:0] tick;
    logic [1:0] pending;

    logic [2:0] en3   = 3'b000;
    logic       we3   = 1'b0;
    logic [1:0] sel3  = 2'd0;
    logic [7:0] data3 = 8'd0;
    logic [2:0] out3;
    logic [2:0] tick3;
    logic [2:0] pend3;

    int pass_cnt  = 0;
    int total_cnt = 0;
    vec_t vecs[$];

    always #5 in_clk = ~in_clk;

    clock_divider_prog #(.CNT_W(8), .NUM_CH(2), .DEFAULT_DIV(3)) u_dut (
        .in_clk  (in_clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_we  (div_we),
        .div_sel (div_sel),
        .div_data(div_data),
        .out_clk (out_clk),
        .tick    (tick),
        .pending (pending)
    );

    clock_divider_prog #(.CNT_W(8), .NUM_CH(3), .DEFAULT_DIV(2)) u_dut3 (
        .in_clk  (in_clk),
        .rst_n   (rst_n),
        .en      (en3),
        .div_we  (we3),
        .div_sel (sel3),
        .div_data(data3),
        .out_clk (out3),
        .tick    (tick3),
        .pending (pend3)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    function automatic vec_t r(logic [1:0] e, logic [1:0] t, logic [1:0] o, logic [1:0] p);
        vec_t v;
        v = '{e, 1'b0, 1'b0, 8'd0, t, o, p};
        return v;
    endfunction

    function automatic vec_t w(logic [1:0] e, logic s, logic [7:0] d,
                               logic [1:0] t, logic [1:0] o, logic [1:0] p);
        vec_t v;
        v = '{e, 1'b1, s, d, t, o, p};
        return v;
    endfunction

    initial begin
        // Cycles 1-12: both channels at reset divisor 3.
        vecs.push_back(r(2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b11, 2'b11, 2'b00));
        vecs.push_back(r(2'b11, 2'b00, 2'b11, 2'b00));
        vecs.push_back(r(2'b11, 2'b00, 2'b11, 2'b00));
        vecs.push_back(r(2'b11, 2'b00, 2'b11, 2'b00));
        vecs.push_back(r(2'b11, 2'b11, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b00, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b11, 2'b11, 2'b00));
        // Cycles 13-21: ch1 disabled, divisor 0 written, then re-enabled.
        vecs.push_back(w(2'b01, 1'b1, 8'd0, 2'b00, 2'b01, 2'b10));
        vecs.push_back(r(2'b01, 2'b00, 2'b01, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b11, 2'b00));
        vecs.push_back(r(2'b11, 2'b11, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b11, 2'b01, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b11, 2'b00));
        // Cycles 22-35: ch0 gets 5 at count 1, adopted at the following wrap.
        vecs.push_back(w(2'b11, 1'b0, 8'd5, 2'b10, 2'b01, 2'b01));
        vecs.push_back(r(2'b11, 2'b10, 2'b11, 2'b01));
        vecs.push_back(r(2'b11, 2'b11, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b11, 2'b01, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b11, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b01, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b11, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b01, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b11, 2'b00));
        // Cycles 36-44: 7 written on the wrap edge takes effect at once.
        vecs.push_back(w(2'b11, 1'b0, 8'd7, 2'b11, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b11, 2'b01, 2'b00));
        // Cycles 45-56: ch0 dropped at count 2 / out high, then re-enabled.
        vecs.push_back(r(2'b11, 2'b10, 2'b11, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b01, 2'b00));
        vecs.push_back(r(2'b10, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b10, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b00, 2'b00));
        vecs.push_back(r(2'b11, 2'b10, 2'b10, 2'b00));
        vecs.push_back(r(2'b11, 2'b11, 2'b01, 2'b00));

        // Reset state
        step();
        step();
        chk("rst out_clk", {6'd0, out_clk}, 8'd0);
        chk("rst tick", {6'd0, tick}, 8'd0);
        chk("rst pending", {6'd0, pending}, 8'd0);
        chk("rst pend3", {5'd0, pend3}, 8'd0);

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            en       = vecs[i].en;
            div_we   = vecs[i].we;
            div_sel  = vecs[i].sel;
            div_data = vecs[i].data;
            step();
            chk($sformatf("c%0d tick", i + 1), {6'd0, tick}, {6'd0, vecs[i].tick});
            chk($sformatf("c%0d out_clk", i + 1), {6'd0, out_clk}, {6'd0, vecs[i].oclk});
            chk($sformatf("c%0d pending", i + 1), {6'd0, pending}, {6'd0, vecs[i].pend});
        end

        // Async reset mid-period with a pending write and outputs high
        div_we = 1'b1; div_sel = 1'b0; div_data = 8'd2;
        step();
        div_we = 1'b0;
        chk("pre-rst pending", {6'd0, pending}, 8'b01);
        chk("pre-rst out_clk", {6'd0, out_clk}, 8'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_clk", {6'd0, out_clk}, 8'd0);
        chk("async rst tick", {6'd0, tick}, 8'd0);
        chk("async rst pending", {6'd0, pending}, 8'd0);
        step();
        rst_n = 1'b1;
        en = 2'b01;
        for (int s = 1; s <= 8; s++) begin
            step();
            chk($sformatf("post-rst s%0d tick0", s), {7'd0, tick[0]}, (s % 4 == 0) ? 8'd1 : 8'd0);
        end
        en = 2'b00;

        // Three-channel instance: out-of-range select is ignored
        we3 = 1'b1; sel3 = 2'd3; data3 = 8'd0;
        step();
        we3 = 1'b0;
        chk("sel3 ignored pend", {5'd0, pend3}, 8'd0);
        en3 = 3'b111;
        step();
        chk("sel3 e1 tick", {5'd0, tick3}, 8'd0);
        step();
        chk("sel3 e2 tick", {5'd0, tick3}, 8'd0);
        step();
        chk("sel3 e3 tick", {5'd0, tick3}, 8'b111);

        // Valid write to ch2 while disabled is adopted before re-enable
        en3 = 3'b000; we3 = 1'b1; sel3 = 2'd2; data3 = 8'd0;
        step();
        we3 = 1'b0;
        chk("ch2 write pend", {5'd0, pend3}, 8'b100);
        step();
        chk("ch2 applied pend", {5'd0, pend3}, 8'd0);
        en3 = 3'b111;
        step();
        chk("ch2 div0 e1 tick", {5'd0, tick3}, 8'b100);
        step();
        chk("ch2 div0 e2 tick", {5'd0, tick3}, 8'b100);
        chk("ch2 div0 e2 out", {5'd0, out3}, 8'b000);
        step();
        chk("ch2 div0 e3 tick", {5'd0, tick3}, 8'b111);
        chk("ch2 div0 e3 out", {5'd0, out3}, 8'b111);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
